// File: rtl/roll_scheduler_pkg.sv
// Shared types and constants for the dice/lottery roll scheduler.
// Holds the FSM encoding, phase codes, generator seed and counter widths.
package roll_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FAST,
        ST_MID,
        ST_SLOW,
        ST_CAPTURE
    } roll_state_t;

    localparam logic [1:0] PHASE_IDLE = 2'd0;
    localparam logic [1:0] PHASE_FAST = 2'd1;
    localparam logic [1:0] PHASE_MID  = 2'd2;
    localparam logic [1:0] PHASE_SLOW = 2'd3;

    localparam logic [3:0] SEED = 4'd15;

    localparam int CNT_W  = 27;
    localparam int STEP_W = 8;

    // CAPTURE reports as the slow phase so the display never sees a phase gap.
    function automatic logic [1:0] phase_of(roll_state_t s);
        logic [1:0] p;
        p = PHASE_IDLE;
        case (s)
            ST_FAST:    p = PHASE_FAST;
            ST_MID:     p = PHASE_MID;
            ST_SLOW:    p = PHASE_SLOW;
            ST_CAPTURE: p = PHASE_SLOW;
            default:    p = PHASE_IDLE;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/roll_scheduler_if.sv
// Bundle of key-side requests, generator feedback and scheduler outputs.
// slave is the scheduler side, master the debouncer/generator/display side.
interface roll_if;
    logic       i_start;
    logic       i_stop;
    logic [3:0] i_rand;
    logic       o_seed_load;
    logic       o_step;
    logic [1:0] o_phase;
    logic       o_busy;
    logic       o_done;
    logic [3:0] o_result;
    logic [3:0] o_prev_result;

    modport slave (
        input  i_start, i_stop, i_rand,
        output o_seed_load, o_step, o_phase, o_busy, o_done, o_result, o_prev_result
    );

    modport master (
        output i_start, i_stop, i_rand,
        input  o_seed_load, o_step, o_phase, o_busy, o_done, o_result, o_prev_result
    );
endinterface

// File: rtl/roll_scheduler_step_timer.sv
// Loadable down-counter pacing generator steps; tick is combinational from the count.
// Load has priority over counting; the count holds at zero and whenever run is low.
module step_timer
    import roll_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             run,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (run && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    assign tick = run && (cnt_q == '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/roll_scheduler.sv
// Roll sequencer: seed load, then fast/mid/slow generator steps, then result capture.
// All outputs registered (one cycle after the deciding input); start restarts, stop jumps to capture.
module roll_scheduler
    import roll_pkg::*;
#(
    parameter int INT_FAST   = 1_000_000,
    parameter int INT_MID    = 4_000_000,
    parameter int INT_SLOW   = 16_000_000,
    parameter int STEPS_FAST = 16,
    parameter int STEPS_MID  = 8,
    parameter int STEPS_SLOW = 4
) (
    input  logic  i_clk,
    input  logic  i_rst,
    roll_if.slave bus
);

    localparam logic [CNT_W-1:0]  LD_FAST = CNT_W'(INT_FAST - 1);
    localparam logic [CNT_W-1:0]  LD_MID  = CNT_W'(INT_MID - 1);
    localparam logic [CNT_W-1:0]  LD_SLOW = CNT_W'(INT_SLOW - 1);
    localparam logic [STEP_W-1:0] N_FAST  = STEP_W'(STEPS_FAST);
    localparam logic [STEP_W-1:0] N_MID   = STEP_W'(STEPS_MID);
    localparam logic [STEP_W-1:0] N_SLOW  = STEP_W'(STEPS_SLOW);

    roll_state_t       state_q, state_d;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
    logic              seed_q, seed_d;
    logic              step_q, step_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic [1:0]        phase_q, phase_d;
    logic [3:0]        result_q, result_d;
    logic [3:0]        prev_q, prev_d;

    logic              tmr_load;
    logic [CNT_W-1:0]  tmr_val;
    logic              tmr_run;
    logic              tick;
    logic              active;
    logic              slow_full;
    logic [STEP_W-1:0] step_nxt;

    step_timer u_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .run      (tmr_run),
        .tick     (tick)
    );

    always_comb begin
        active     = (state_q == ST_FAST) || (state_q == ST_MID) || (state_q == ST_SLOW);
        // Final slow step already issued: hold SLOW one cycle so capture sees the settled value.
        slow_full  = (state_q == ST_SLOW) && (step_cnt_q == N_SLOW);
        tmr_run    = active && !slow_full;
        step_nxt   = step_cnt_q + 1'b1;

        state_d    = state_q;
        step_cnt_d = step_cnt_q;
        tmr_load   = 1'b0;
        tmr_val    = LD_FAST;
        seed_d     = 1'b0;
        step_d     = 1'b0;
        done_d     = 1'b0;
        result_d   = result_q;
        prev_d     = prev_q;

        case (state_q)
            ST_FAST: begin
                if (tick) begin
                    step_d   = 1'b1;
                    tmr_load = 1'b1;
                    if (step_nxt == N_FAST) begin
                        state_d    = ST_MID;
                        tmr_val    = LD_MID;
                        step_cnt_d = '0;
                    end else begin
                        tmr_val    = LD_FAST;
                        step_cnt_d = step_nxt;
                    end
                end
            end
            ST_MID: begin
                if (tick) begin
                    step_d   = 1'b1;
                    tmr_load = 1'b1;
                    if (step_nxt == N_MID) begin
                        state_d    = ST_SLOW;
                        tmr_val    = LD_SLOW;
                        step_cnt_d = '0;
                    end else begin
                        tmr_val    = LD_MID;
                        step_cnt_d = step_nxt;
                    end
                end
            end
            ST_SLOW: begin
                if (slow_full) begin
                    state_d = ST_CAPTURE;
                end else if (tick) begin
                    step_d     = 1'b1;
                    step_cnt_d = step_nxt;
                    if (step_nxt != N_SLOW) begin
                        tmr_load = 1'b1;
                        tmr_val  = LD_SLOW;
                    end
                end
            end
            ST_CAPTURE: begin
                state_d  = ST_IDLE;
                done_d   = 1'b1;
                result_d = bus.i_rand;
                prev_d   = result_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (active && bus.i_stop) begin
            state_d  = ST_CAPTURE;
            step_d   = 1'b0;
            tmr_load = 1'b0;
        end

        // Start overrides everything, including a simultaneous stop or a pending capture.
        if (bus.i_start) begin
            state_d    = ST_FAST;
            step_cnt_d = '0;
            tmr_load   = 1'b1;
            tmr_val    = LD_FAST;
            seed_d     = 1'b1;
            step_d     = 1'b0;
            done_d     = 1'b0;
            result_d   = result_q;
            prev_d     = prev_q;
        end

        busy_d  = (state_d != ST_IDLE);
        phase_d = phase_of(state_d);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            step_cnt_q <= '0;
            seed_q     <= 1'b0;
            step_q     <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            phase_q    <= PHASE_IDLE;
            result_q   <= '0;
            prev_q     <= '0;
        end else begin
            state_q    <= state_d;
            step_cnt_q <= step_cnt_d;
            seed_q     <= seed_d;
            step_q     <= step_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            phase_q    <= phase_d;
            result_q   <= result_d;
            prev_q     <= prev_d;
        end
    end

    assign bus.o_seed_load   = seed_q;
    assign bus.o_step        = step_q;
    assign bus.o_done        = done_q;
    assign bus.o_busy        = busy_q;
    assign bus.o_phase       = phase_q;
    assign bus.o_result      = result_q;
    assign bus.o_prev_result = prev_q;

endmodule

// File: tb/tb_roll_scheduler.sv
// Scoreboard bench for roll_scheduler with short intervals (2/3/5) and steps (4/2/2).
// Stimulus queues cycle-stamped expected events; the monitor matches every output pulse and snapshot.
module tb_roll_scheduler;

    localparam int K_SEED = 0;
    localparam int K_STEP = 1;
    localparam int K_DONE = 2;
    localparam int K_SNAP = 3;

    typedef struct {
        int         cyc;
        int         kind;
        logic       seed;
        logic       step;
        logic       done;
        logic       busy;
        logic [1:0] phase;
        logic [3:0] res;
        logic [3:0] prev;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    ev_t  exp_q[$];
    logic [3:0] m_res = 4'd0;
    logic [3:0] m_prev = 4'd0;

    int    step_off[8] = '{3, 5, 7, 9, 12, 15, 20, 25};
    int    step_ph[8]  = '{1, 1, 1, 2, 2, 3, 3, 3};
    string kname[4]    = '{"seed", "step", "done", "snap"};

    roll_if rif();

    roll_scheduler #(
        .INT_FAST   (2),
        .INT_MID    (3),
        .INT_SLOW   (5),
        .STEPS_FAST (4),
        .STEPS_MID  (2),
        .STEPS_SLOW (2)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (rif)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk(input int c, input int k, input logic sd, input logic st,
                               input logic dn, input logic bs, input logic [1:0] ph,
                               input logic [3:0] r, input logic [3:0] p);
        ev_t e;
        e.cyc = c; e.kind = k; e.seed = sd; e.step = st; e.done = dn;
        e.busy = bs; e.phase = ph; e.res = r; e.prev = p;
        return e;
    endfunction

    // Keep the queue ordered by cycle, then by the order the monitor checks kinds.
    function automatic void push(input ev_t e);
        int i = 0;
        while (i < exp_q.size() &&
               (exp_q[i].cyc < e.cyc || (exp_q[i].cyc == e.cyc && exp_q[i].kind <= e.kind)))
            i++;
        exp_q.insert(i, e);
    endfunction

    function automatic void push_finish(input int c, input logic [3:0] r0,
                                        input logic [3:0] p0, input logic [3:0] r1);
        push(mk(c,     K_SNAP, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, r0, p0));
        push(mk(c + 1, K_DONE, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, r1, r0));
        push(mk(c + 2, K_SNAP, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, r1, r0));
    endfunction

    function automatic void push_roll(input int base, input int upto, input logic [3:0] r0,
                                      input logic [3:0] p0, input logic [3:0] r1);
        push(mk(base + 1, K_SEED, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, r0, p0));
        for (int k = 0; k < 8; k++)
            if (step_off[k] <= upto)
                push(mk(base + step_off[k], K_STEP, 1'b0, 1'b1, 1'b0, 1'b1, 2'(step_ph[k]), r0, p0));
        if (upto >= 25)
            push_finish(base + 26, r0, p0, r1);
    endfunction

    task automatic check(input int k);
        ev_t e;
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc || exp_q[0].kind != k) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_%s at cycle %0d (required: no such event)", kname[k], cyc);
        end else begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({rif.o_seed_load, rif.o_step, rif.o_done, rif.o_busy, rif.o_phase,
                 rif.o_result, rif.o_prev_result} !==
                {e.seed, e.step, e.done, e.busy, e.phase, e.res, e.prev}) begin
                n_err++;
                $display("FAIL %s cycle %0d: got seed=%b step=%b done=%b busy=%b phase=%0d res=%0d prev=%0d, want seed=%b step=%b done=%b busy=%b phase=%0d res=%0d prev=%0d",
                         kname[k], cyc, rif.o_seed_load, rif.o_step, rif.o_done, rif.o_busy,
                         rif.o_phase, rif.o_result, rif.o_prev_result,
                         e.seed, e.step, e.done, e.busy, e.phase, e.res, e.prev);
            end
        end
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            n_cmp++;
            n_err++;
            $display("FAIL missing_%s: due cycle %0d, not seen by cycle %0d",
                     kname[exp_q[0].kind], exp_q[0].cyc, cyc);
            void'(exp_q.pop_front());
        end
        if (rif.o_seed_load) check(K_SEED);
        if (rif.o_step)      check(K_STEP);
        if (rif.o_done)      check(K_DONE);
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc && exp_q[0].kind == K_SNAP) check(K_SNAP);
    end

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic roll(input int upto, input logic [3:0] r1, input logic with_stop,
                        output int base);
        @(negedge clk);
        base = cyc;
        rif.i_start = 1'b1;
        rif.i_stop  = with_stop;
        push_roll(base, upto, m_res, m_prev, r1);
        @(negedge clk);
        rif.i_start = 1'b0;
        rif.i_stop  = 1'b0;
    endtask

    initial begin
        int b;
        int b2;
        rif.i_start = 1'b0;
        rif.i_stop  = 1'b0;
        rif.i_rand  = 4'd0;

        push(mk(2, K_SNAP, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0));
        wait_to(3);
        rst = 1'b0;

        // Full roll, then a second to check result history.
        rif.i_rand = 4'd6;
        roll(25, 4'd6, 1'b0, b);
        m_prev = m_res; m_res = 4'd6;
        wait_to(b + 30);
        rif.i_rand = 4'd11;
        roll(25, 4'd11, 1'b0, b);
        m_prev = m_res; m_res = 4'd11;
        wait_to(b + 30);

        // Early stop during MID, then idle long enough to catch stray steps.
        rif.i_rand = 4'd3;
        roll(9, 4'd3, 1'b0, b);
        wait_to(b + 10);
        rif.i_stop = 1'b1;
        push_finish(b + 11, m_res, m_prev, 4'd3);
        @(negedge clk);
        rif.i_stop = 1'b0;
        m_prev = m_res; m_res = 4'd3;
        wait_to(b + 20);

        // Restart in MID at cycle 13.
        rif.i_rand = 4'd9;
        roll(12, 4'd9, 1'b0, b);
        wait_to(b + 12);
        roll(25, 4'd9, 1'b0, b2);
        m_prev = m_res; m_res = 4'd9;
        wait_to(b2 + 30);

        // Start and stop together in SLOW.
        rif.i_rand = 4'd5;
        roll(15, 4'd5, 1'b0, b);
        wait_to(b + 17);
        roll(25, 4'd5, 1'b1, b2);
        m_prev = m_res; m_res = 4'd5;
        wait_to(b2 + 30);

        // Asynchronous reset early in cycle 8 of a roll.
        rif.i_rand = 4'd4;
        roll(7, 4'd4, 1'b0, b);
        wait_to(b + 7);
        @(posedge clk);
        #2 rst = 1'b1;
        m_res = 4'd0; m_prev = 4'd0;
        push(mk(cyc, K_SNAP, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        rif.i_rand = 4'd7;
        roll(25, 4'd7, 1'b0, b2);
        m_prev = m_res; m_res = 4'd7;
        wait_to(b2 + 32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/roll_scheduler.md
# roll_scheduler

Sequencing controller for the 4-bit LFSR random generator used by the dice/lottery display. It replaces free-running modulo timing with an explicit schedule. On a roll request it loads the seed, then issues generator step pulses at three progressively slower rates (fast, mid, slow), each for a fixed number of steps. After the last step it captures the settled value as the result, keeps the previous result, and returns to idle. It sits between the key debouncer (`i_start`, `i_stop`) and the generator/seven-segment path.

## Interface
- `INT_FAST`, default 1_000_000: cycles between steps in the fast phase (≥1)
- `INT_MID`, default 4_000_000: cycles between steps in the mid phase (≥1)
- `INT_SLOW`, default 16_000_000: cycles between steps in the slow phase (≥1, <2^27)
- `STEPS_FAST`, default 16: steps issued in the fast phase (≥1, ≤255)
- `STEPS_MID`, default 8: steps issued in the mid phase (≥1, ≤255)
- `STEPS_SLOW`, default 4: steps issued in the slow phase (≥1, ≤255)

Ports:
- `i_clk` in 1: the single clock
- `i_rst` in 1: reset, asynchronous, active-high
- `i_start` in 1: roll request, one-cycle pulse or level
- `i_stop` in 1: early-stop request
- `i_rand` in 4: current generator output
- `o_seed_load` out 1: one-cycle pulse; generator loads seed 4'd15
- `o_step` out 1: one-cycle pulse; generator advances once
- `o_phase` out 2: 0 = idle, 1 = fast, 2 = mid, 3 = slow or capture
- `o_busy` out 1: high from seed load until the done cycle, exclusive
- `o_done` out 1: one-cycle pulse; `o_result` is updated in this cycle
- `o_result` out 4: last captured value
- `o_prev_result` out 4: value captured before `o_result`

## Operation
- FSM states are IDLE, FAST, MID, SLOW, CAPTURE.
- **IDLE:** `i_start` moves to FAST, loads the interval counter with `INT_FAST-1`, clears the step count and pulses `o_seed_load`.
- **Interval counter** (27-bit): in FAST, MID and SLOW it decrements each cycle.
  - At 0 it asserts `o_step`, reloads with the current phase's `INT-1` and increments the step count.
  - When the step count reaches `STEPS_x` on that step, the FSM advances (FAST→MID→SLOW→CAPTURE). The reload uses the new phase's interval and the step count clears.
- **CAPTURE** lasts exactly one cycle. At its end, `o_result <= i_rand`, `o_prev_result <= o_result` and `o_done` pulses next cycle, with the FSM in IDLE.
- **`i_stop`** in FAST, MID or SLOW goes to CAPTURE next cycle and issues no further steps. `i_stop` in IDLE or CAPTURE is ignored.
- **`i_start`** in any non-IDLE state restarts: FAST, seed reload, counters cleared. `o_result` is unchanged and no `o_done` pulse is issued.
- **`i_start` and `i_stop` together:** start wins.
- **Held `i_start`:** a continuously held `i_start` keeps restarting each cycle, so no step ever issues. The debouncer must pulse it.
- **Phase boundary:** `o_step` of the final step in a phase and the phase change occur in the same cycle. No interval is skipped or doubled.

## Timing
- **All outputs are registered.** Reset values:
  - `o_seed_load`, `o_step`, `o_done`, `o_busy` = 0
  - `o_phase` = 0
  - `o_result` = 0, `o_prev_result` = 0
  - state = IDLE, counters = 0
- **Start:** `i_start` sampled high at the end of cycle 0 gives `o_seed_load` = 1, `o_busy` = 1 and `o_phase` = 1 in cycle 1.
- **Step cycles:**
  - Fast steps occur at cycles 1+k·`INT_FAST`, k = 1..`STEPS_FAST`.
  - Mid and slow steps continue at their own intervals from the last step of the previous phase.
- **Finish:** with the final step in cycle F, CAPTURE is cycle F+1 (`i_rand` already reflects step F). In cycle F+2, `o_done` = 1, `o_busy` = 0, `o_phase` = 0 and `o_result` is valid.
- **Early stop:** `i_stop` sampled in cycle S gives CAPTURE in S+1 and done in S+2.
- **Reset mid-roll:** all outputs return to reset values immediately, with no done pulse. The first cycle after reset release is IDLE.

## Structure
- Package `roll_pkg`:
  - `roll_state_t` enum (5 states)
  - phase encoding constants `PHASE_IDLE/FAST/MID/SLOW`
  - `SEED = 4'd15`
  - `CNT_W = 27`, `STEP_W = 8`
- Sub-module `step_timer`: loadable 27-bit down-counter with `load`, `load_val`, `run` inputs and a `tick` output asserted when the count is 0 while running. `roll_scheduler` instantiates it once and owns the FSM, step count and result registers.

## Test plan
1. **Full roll.** Setup: overrides `INT_FAST=2`, `INT_MID=3`, `INT_SLOW=5`, `STEPS=4/2/2`; `i_start` pulse in cycle 0. Required response:
   - `o_seed_load` in cycle 1
   - `o_step` at cycles 3, 5, 7, 9, 12, 15, 20, 25
   - CAPTURE in cycle 26; `o_done` and the result in cycle 27
   - `o_phase` sequence 1→2→3→0
2. **Result history.** Setup: `i_rand` = 4'd6 during the first roll's capture and 4'd11 during the second's. Required response: after the second done, `o_result` = 11 and `o_prev_result` = 6.
3. **Early stop.** Setup: `i_stop` in cycle 10 of a roll. Required response: no `o_step` after cycle 9, CAPTURE in cycle 11, `o_done` in cycle 12, no further steps.
4. **Restart.** Setup: `i_start` in cycle 13 (MID phase). Required response: `o_seed_load` in cycle 14, `o_phase` = 1, next `o_step` in cycle 16, `o_result` unchanged and no `o_done`.
5. **Start and stop together.** Setup: `i_start` and `i_stop` together in SLOW. Required response: restart behaviour (seed load, FAST), no capture.
6. **Reset mid-roll.** Setup: `i_rst` pulse in cycle 8. Required response: all outputs 0 the same cycle; the next `i_start` gives a normal roll timed as in scenario 1.
